scale_ddr_wr_ctrl: RTL and testbench

- Write-side scheduler between the scaler's output pixel stream (pix_data/data_vaild) and one DDR3 write channel.
- Buffers scaled pixels in an internal FIFO and cuts them into line-bounded bursts.
- Computes each burst address from the frame base address (the scaler's DDR3_ADDR), LINE_STRIDE and target geometry, and sequences request/data/done handshakes per frame.

---
 rtl/scale_wr_pkg.sv | 22 ++
 rtl/pix_sfifo.sv | 64 ++++++
 rtl/scale_ddr_wr_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_scale_ddr_wr_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_wr_pkg.sv
// rtl/scale_wr_pkg.sv - shared types, widths and helpers for the scaler DDR write controller
package scale_wr_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LEN_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_DATA,
    ST_DONE,
    ST_FIN
  } wr_state_t;

  // Burst length for the remainder of a row: never crosses the row end.
  function automatic logic [12:0] min_len(input logic [12:0] burst_max,
                                          input logic [12:0] remain);
    return (remain < burst_max) ? remain : burst_max;
  endfunction

endpackage

// File: rtl/pix_sfifo.sv
// rtl/pix_sfifo.sv - synchronous show-ahead pixel FIFO with occupancy count
module pix_sfifo #(
  parameter int PIX_WIDTH  = 16,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [PIX_WIDTH-1:0]         push_data,
  input  logic                         pop,
  output logic [PIX_WIDTH-1:0]         head,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         full
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

  logic [PIX_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 empty;
  logic                 push_ok;
  logic                 pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Head reads as zero when empty so the data output idles at 0 after reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scale_ddr_wr_ctrl.sv
// rtl/scale_ddr_wr_ctrl.sv - buffers scaled pixels and issues line-bounded DDR write bursts
module scale_ddr_wr_ctrl
  import scale_wr_pkg::*;
#(
  parameter int PIX_WIDTH   = 16,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BURST_LEN   = 64,
  parameter int LINE_STRIDE = 640,
  parameter int FIFO_DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [12:0]          h_num,
  input  logic [12:0]          v_num,
  input  logic [PIX_WIDTH-1:0] pix_data,
  input  logic                 pix_vaild,
  output logic                 wr_req,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [LEN_W-1:0]     wr_len,
  input  logic                 wr_ack,
  input  logic                 wr_data_req,
  output logic [PIX_WIDTH-1:0] wr_data,
  input  logic                 wr_done,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 ovf_err
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int STRIDE_W = $clog2(LINE_STRIDE + 1);
  localparam int PROD_W   = 13 + STRIDE_W;
  localparam logic [12:0]         BURST_C  = 13'(BURST_LEN);
  localparam logic [STRIDE_W-1:0] STRIDE_C = STRIDE_W'(LINE_STRIDE);

  wr_state_t         state;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] row_off_r;
  logic [12:0]       h_r;
  logic [12:0]       v_r;
  logic [12:0]       row;
  logic [12:0]       col;
  logic [12:0]       col_next;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  beat_cnt;
  logic              wait_vld;
  logic              hit_q;
  logic              done_pend;
  logic [PROD_W-1:0] row_prod;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              start_ok;
  logic              push_req;
  logic              pop;

  assign start_ok = frame_start && (state == ST_IDLE);
  // Pixels outside a frame are dropped silently.
  assign push_req = pix_vaild && (state != ST_IDLE);
  assign pop      = (state == ST_DATA) && wr_data_req && (beat_cnt < wr_len);
  assign row_prod = PROD_W'(row) * PROD_W'(STRIDE_C);
  assign col_next = col + 13'(wr_len);

  pix_sfifo #(
    .PIX_WIDTH  (PIX_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (start_ok),
    .push      (push_req),
    .push_data (pix_data),
    .pop       (pop),
    .head      (wr_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // Sticky overflow flag: a pixel lost because the FIFO was full with no pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_err <= 1'b0;
    end else if (start_ok) begin
      ovf_err <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      ovf_err <= 1'b1;
    end
  end

  // Frame/burst sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      base_r     <= '0;
      row_off_r  <= '0;
      h_r        <= '0;
      v_r        <= '0;
      row        <= '0;
      col        <= '0;
      len_r      <= '0;
      beat_cnt   <= '0;
      wait_vld   <= 1'b0;
      hit_q      <= 1'b0;
      done_pend  <= 1'b0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_len     <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            base_r     <= base_addr;
            h_r        <= h_num;
            v_r        <= v_num;
            row        <= '0;
            col        <= '0;
            done_pend  <= 1'b0;
            wait_vld   <= 1'b0;
            hit_q      <= 1'b0;
            frame_busy <= 1'b1;
            state      <= (h_num == '0 || v_num == '0) ? ST_FIN : ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Length and row offset settle one cycle, the threshold hit another,
          // so the request always leaves from registered values.
          len_r     <= LEN_W'(min_len(BURST_C, h_r - col));
          row_off_r <= ADDR_W'(row_prod);
          wait_vld  <= 1'b1;
          hit_q     <= wait_vld && (32'(fifo_count) >= 32'(len_r));
          if (hit_q) begin
            wr_addr  <= base_r + row_off_r + ADDR_W'(col);
            wr_len   <= len_r;
            wr_req   <= 1'b1;
            wait_vld <= 1'b0;
            hit_q    <= 1'b0;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wr_ack) begin
            wr_req   <= 1'b0;
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_done) done_pend <= 1'b1;
          if (pop) beat_cnt <= beat_cnt + LEN_W'(1);
          if (beat_cnt == wr_len) state <= ST_DONE;
        end
        ST_DONE: begin
          if (wr_done || done_pend) begin
            done_pend <= 1'b0;
            if (col_next == h_r) begin
              col <= '0;
              row <= row + 13'd1;
              if ((row + 13'd1) == v_r) begin
                frame_done <= 1'b1;
                frame_busy <= 1'b0;
                state      <= ST_FIN;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              col   <= col_next;
              state <= ST_WAIT;
            end
          end
        end
        ST_FIN: begin
          // Entered busy from a degenerate frame: pulse done here first.
          if (frame_busy) begin
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_ddr_wr_ctrl.sv
// tb/tb_scale_ddr_wr_ctrl.sv - directed self-checking bench for scale_ddr_wr_ctrl
module tb_scale_ddr_wr_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        frame_start;
  logic [27:0] base_addr;
  logic [12:0] h_num;
  logic [12:0] v_num;
  logic [15:0] pix_data;
  logic        pix_vaild;
  logic        wr_req;
  logic [27:0] wr_addr;
  logic [7:0]  wr_len;
  logic        wr_ack;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        wr_done;
  logic        frame_busy;
  logic        frame_done;
  logic        ovf_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_pix  = 0;

  scale_ddr_wr_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .h_num       (h_num),
    .v_num       (v_num),
    .pix_data    (pix_data),
    .pix_vaild   (pix_vaild),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_len      (wr_len),
    .wr_ack      (wr_ack),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .wr_done     (wr_done),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .ovf_err     (ovf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic start_frame(input logic [27:0] b, input logic [12:0] h, input logic [12:0] v);
    base_addr   = b;
    h_num       = h;
    v_num       = v;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic push_pix(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      pix_vaild = 1'b1;
      pix_data  = 16'(first + i);
      @(negedge clk);
    end
    pix_vaild = 1'b0;
  endtask

  task automatic serve_burst(input logic [27:0] ea, input logic [7:0] el);
    int t = 0;
    while (wr_req !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wr_req !== 1'b1) begin
      failures++;
      $display("FAIL burst_req_timeout wr_req=%b required=1", wr_req);
      return;
    end
    checks++;
    if (wr_addr !== ea) begin
      failures++;
      $display("FAIL burst_addr got=%h required=%h", wr_addr, ea);
    end
    checks++;
    if (wr_len !== el) begin
      failures++;
      $display("FAIL burst_len got=%0d required=%0d", wr_len, el);
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    checks++;
    if (wr_req !== 1'b0) begin
      failures++;
      $display("FAIL burst_req_drop got=%b required=0", wr_req);
    end
    for (int i = 0; i < int'(el); i++) begin
      wr_data_req = 1'b1;
      checks++;
      if (wr_data !== 16'(exp_pix)) begin
        failures++;
        $display("FAIL burst_data beat=%0d got=%h required=%h", i, wr_data, 16'(exp_pix));
      end
      exp_pix++;
      @(negedge clk);
    end
    wr_data_req = 1'b0;
    @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_req, frame_busy, frame_done, ovf_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=0000", {wr_req, frame_busy, frame_done, ovf_err});
    end
    checks++;
    if (wr_addr !== 28'h0 || wr_len !== 8'h0) begin
      failures++;
      $display("FAIL reset_addr_len got=%h/%h required=0/0", wr_addr, wr_len);
    end
    checks++;
    if (wr_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", wr_data);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int d0 = done_cnt;
    exp_pix = 16'h0100;
    start_frame(28'h140, 13'd8, 13'd1);
    checks++;
    if (frame_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy got=%b required=1", frame_busy);
    end
    push_pix(8, 16'h0100);
    serve_burst(28'h140, 8'd8);
    checks++;
    if (frame_done !== 1'b1 || frame_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done_timing done/busy got=%b%b required=10", frame_done, frame_busy);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL single_done_pulse done=%b pulses=%0d required 0 and 1", frame_done, done_cnt - d0);
    end
  endtask

  task automatic test_row_split();
    int d0 = done_cnt;
    exp_pix = 16'h1000;
    start_frame(28'h140, 13'd150, 13'd2);
    fork
      push_pix(300, 16'h1000);
      begin
        serve_burst(28'h140, 8'd64);
        serve_burst(28'h180, 8'd64);
        serve_burst(28'h1C0, 8'd22);
        serve_burst(28'h3C0, 8'd64);
        serve_burst(28'h400, 8'd64);
        serve_burst(28'h440, 8'd22);
      end
    join
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL split_done_count got=%0d required=1", done_cnt - d0);
    end
    checks++;
    if (frame_busy !== 1'b0 || ovf_err !== 1'b0 || wr_req !== 1'b0) begin
      failures++;
      $display("FAIL split_end_state busy/ovf/req got=%b%b%b required=000", frame_busy, ovf_err, wr_req);
    end
  endtask

  task automatic test_overflow();
    exp_pix = 16'h4000;
    start_frame(28'h0, 13'd64, 13'd1);
    push_pix(256, 16'h4000);
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_at_full got=%b required=0", ovf_err);
    end
    push_pix(3, 16'h5000);
    checks++;
    if (ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b required=1", ovf_err);
    end
    serve_burst(28'h0, 8'd64);
    repeat (3) @(negedge clk);
    checks++;
    if (ovf_err !== 1'b1 || frame_busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_sticky ovf/busy got=%b%b required=10", ovf_err, frame_busy);
    end
    start_frame(28'h0, 13'd0, 13'd5);
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b required=0", ovf_err);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_degenerate();
    int d0 = done_cnt;
    start_frame(28'h140, 13'd8, 13'd0);
    checks++;
    if ({frame_busy, frame_done, wr_req} !== 3'b100) begin
      failures++;
      $display("FAIL degen_cycle1 busy/done/req got=%b required=100", {frame_busy, frame_done, wr_req});
    end
    @(negedge clk);
    checks++;
    if ({frame_busy, frame_done, wr_req} !== 3'b010) begin
      failures++;
      $display("FAIL degen_cycle2 busy/done/req got=%b required=010", {frame_busy, frame_done, wr_req});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || wr_req !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL degen_after pulses=%0d req=%b done=%b required 1,0,0", done_cnt - d0, wr_req, frame_done);
    end
  endtask

  task automatic test_abuse();
    int d0;
    int t = 0;
    exp_pix = 16'h2000;
    start_frame(28'h200, 13'd8, 13'd1);
    push_pix(10, 16'h2000);
    while (wr_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wr_req !== 1'b1 || wr_addr !== 28'h200 || wr_len !== 8'd8) begin
      failures++;
      $display("FAIL abuse_req req=%b addr=%h len=%0d required 1,200,8", wr_req, wr_addr, wr_len);
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      wr_data_req = 1'b1;
      wr_done     = (i == 4);
      frame_start = (i == 2);
      base_addr   = 28'hABC;
      h_num       = 13'd4;
      v_num       = 13'd4;
      if (i < 8) begin
        checks++;
        if (wr_data !== 16'(exp_pix)) begin
          failures++;
          $display("FAIL abuse_data beat=%0d got=%h required=%h", i, wr_data, 16'(exp_pix));
        end
        exp_pix++;
      end
      @(negedge clk);
    end
    wr_data_req = 1'b0;
    wr_done     = 1'b0;
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || frame_busy !== 1'b0) begin
      failures++;
      $display("FAIL abuse_complete pulses=%0d busy=%b required 1,0", done_cnt - d0, frame_busy);
    end
    checks++;
    if (wr_data !== 16'h2008) begin
      failures++;
      $display("FAIL abuse_pop_count head got=%h required=2008", wr_data);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int d0;
    start_frame(28'h140, 13'd8, 13'd1);
    push_pix(8, 16'h3000);
    while (wr_req !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    wr_data_req = 1'b1;
    repeat (3) @(negedge clk);
    wr_data_req = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({wr_req, frame_busy, frame_done, ovf_err} !== 4'b0000 || wr_addr !== 28'h0 ||
        wr_len !== 8'h0 || wr_data !== 16'h0) begin
      failures++;
      $display("FAIL midreset_outputs flags=%b addr=%h len=%h data=%h required all 0",
               {wr_req, frame_busy, frame_done, ovf_err}, wr_addr, wr_len, wr_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    exp_pix = 16'h3100;
    start_frame(28'h300, 13'd4, 13'd2);
    fork
      push_pix(8, 16'h3100);
      begin
        serve_burst(28'h300, 8'd4);
        serve_burst(28'h580, 8'd4);
      end
    join
    checks++;
    if (frame_done !== 1'b1 || done_cnt - d0 != 0) begin
      failures++;
      $display("FAIL midreset_fresh_done done=%b prior_pulses=%0d required 1,0", frame_done, done_cnt - d0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rstn        = 1'b0;
    frame_start = 1'b0;
    base_addr   = '0;
    h_num       = '0;
    v_num       = '0;
    pix_data    = '0;
    pix_vaild   = 1'b0;
    wr_ack      = 1'b0;
    wr_data_req = 1'b0;
    wr_done     = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_row_split();
    test_overflow();
    test_degenerate();
    test_abuse();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
